// File: rtl/rv_trace_checker.sv
// Trace checker: compares the committed PC/instruction stream against a preloaded expected trace.
// Latency: counters and status reflect a commit one cycle after the commit cycle.
// Backpressure: none; purely observational, commits outside RUN are dropped.
module rv_trace_checker #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 64,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 1024,
    parameter bit CMP_INSTR = 1'b1,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [XLEN-1:0]  ld_pc,
    input  logic [XLEN-1:0]  ld_instr,
    input  logic [AW:0]      trace_len,
    input  logic             start,
    input  logic             commit_vld,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [XLEN-1:0]  instr_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] correct_cnt,
    output logic [CNT_W-1:0] error_cnt,
    output logic [AW-1:0]    err_idx,
    output logic [XLEN-1:0]  err_pc
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [XLEN-1:0] mem_instr [DEPTH];
    logic [AW:0]     len;
    logic [AW-1:0]   idx;
    logic [TW-1:0]   timer;
    logic            start_ok;
    logic            match;
    logic            last;

    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign start_ok = start && (trace_len != '0) && (trace_len <= DEPTH_L);
    assign match    = (pc_in == mem_pc[idx]) && (!CMP_INSTR || (instr_in == mem_instr[idx]));
    assign last     = ({1'b0, idx} == (AW+1)'(len - 1'b1));

    // Expected trace has no reset; it is only writable while idle so a run sees a frozen trace.
    always_ff @(posedge clk) begin
        if (ld_en && state == IDLE) begin
            mem_pc[ld_addr]    <= ld_pc;
            mem_instr[ld_addr] <= ld_instr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            len         <= '0;
            idx         <= '0;
            timer       <= '0;
            correct_cnt <= '0;
            error_cnt   <= '0;
            err_idx     <= '0;
            err_pc      <= '0;
            timeout     <= 1'b0;
            pass        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state       <= RUN;
                        len         <= trace_len;
                        idx         <= '0;
                        timer       <= '0;
                        correct_cnt <= '0;
                        error_cnt   <= '0;
                        err_idx     <= '0;
                        err_pc      <= '0;
                        timeout     <= 1'b0;
                        pass        <= 1'b0;
                    end
                end
                RUN: begin
                    if (commit_vld) begin
                        timer <= '0;
                        idx   <= idx + 1'b1;
                        if (match) begin
                            if (correct_cnt != CNT_MAX) correct_cnt <= correct_cnt + 1'b1;
                        end else begin
                            if (error_cnt != CNT_MAX) error_cnt <= error_cnt + 1'b1;
                            // error_cnt never returns to zero mid-run, so zero marks the first mismatch
                            if (error_cnt == '0) begin
                                err_idx <= idx;
                                err_pc  <= pc_in;
                            end
                        end
                        if (last) begin
                            state <= DONE;
                            pass  <= match && (error_cnt == '0);
                        end
                    end else if (timer == TIMER_LAST) begin
                        state   <= DONE;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
